// File: rtl/arm_countdown_ctrl.sv
// Countdown sequencer for the alarm arming/entry delays: loads a seconds value,
// decrements once per CLK_HZ cycles and flags expiry to the system FSM.
module arm_countdown_ctrl #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int ARM_S   = 30,
  parameter int ENTRY_S = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_arm,
  input  logic       start_entry,
  input  logic       cancel,
  input  logic       hold,
  output logic [6:0] timer,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       sec_tick
);

  localparam int            PW       = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PMAX     = PW'(CLK_HZ - 1);
  localparam logic [6:0]    ARM_LD   = 7'(ARM_S);
  localparam logic [6:0]    ENTRY_LD = 7'(ENTRY_S);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_EXPIRED
  } state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [6:0]    timer_q;
  logic          running_q;
  logic          expired_q;
  logic          done_q;
  logic          tick_q;

  logic          start_d;
  logic [6:0]    load_d;
  logic          wrap_d;
  logic          tick_d;

  // start_arm wins when both requests arrive together
  assign start_d = start_arm | start_entry;
  assign load_d  = start_arm ? ARM_LD : ENTRY_LD;
  assign wrap_d  = (presc_q == PMAX) && !hold;
  assign tick_d  = wrap_d && (timer_q != 7'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      timer_q   <= 7'd0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else if (cancel) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      timer_q   <= 7'd0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      tick_q    <= 1'b0;
      case (state_q)
        S_IDLE, S_EXPIRED: begin
          if (start_d) begin
            state_q   <= S_COUNT;
            presc_q   <= '0;
            timer_q   <= load_d;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        S_COUNT: begin
          // hold freezes the prescaler too, so the partial second survives
          if (!hold) begin
            if (wrap_d) presc_q <= '0;
            else        presc_q <= presc_q + PW'(1);
          end
          if (tick_d) begin
            tick_q  <= 1'b1;
            timer_q <= timer_q - 7'd1;
            if (timer_q == 7'd1) begin
              state_q   <= S_EXPIRED;
              expired_q <= 1'b1;
              done_q    <= 1'b1;
              running_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          presc_q   <= '0;
          timer_q   <= 7'd0;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign timer    = timer_q;
  assign running  = running_q;
  assign expired  = expired_q;
  assign done     = done_q;
  assign sec_tick = tick_q;

endmodule

// File: tb/tb_arm_countdown_ctrl.sv
// Directed bench for arm_countdown_ctrl with CLK_HZ=4, ARM_S=3, ENTRY_S=2.
module tb_arm_countdown_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_arm;
  logic       start_entry;
  logic       cancel;
  logic       hold;
  logic [6:0] timer;
  logic       running;
  logic       expired;
  logic       done;
  logic       sec_tick;

  int n_cmp = 0;
  int n_err = 0;

  arm_countdown_ctrl #(
    .CLK_HZ (4),
    .ARM_S  (3),
    .ENTRY_S(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_arm  (start_arm),
    .start_entry(start_entry),
    .cancel     (cancel),
    .hold       (hold),
    .timer      (timer),
    .running    (running),
    .expired    (expired),
    .done       (done),
    .sec_tick   (sec_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_timer"}, 32'(timer), 0);
    chk({tag, "_running"}, 32'(running), 0);
    chk({tag, "_expired"}, 32'(expired), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_tick"}, 32'(sec_tick), 0);
  endtask

  // Full arm countdown after the start edge: timer 3 -> 0 at 4-cycle spacing
  task automatic run_arm(input string tag);
    for (int c = 1; c <= 12; c++) begin
      step();
      chk({tag, "_timer"}, 32'(timer), 32'(3 - c / 4));
      chk({tag, "_tick"}, 32'(sec_tick), 32'((c % 4) == 0));
      chk({tag, "_expired"}, 32'(expired), 32'(c == 12));
      chk({tag, "_running"}, 32'(running), 32'(c != 12));
    end
    chk({tag, "_done"}, 32'(done), 1);
    step();
    chk({tag, "_expired_once"}, 32'(expired), 0);
    chk({tag, "_tick_once"}, 32'(sec_tick), 0);
    chk({tag, "_done_hold"}, 32'(done), 1);
    chk({tag, "_timer_zero"}, 32'(timer), 0);
  endtask

  initial begin
    rst_n = 1'b0; start_arm = 1'b0; start_entry = 1'b0; cancel = 1'b0; hold = 1'b0;
    step(); step();
    chk_idle("reset");
    rst_n = 1'b1;
    step();
    chk_idle("post_reset");

    // basic arm count
    start_arm = 1'b1;
    step();
    start_arm = 1'b0;
    chk("arm_load_timer", 32'(timer), 3);
    chk("arm_load_running", 32'(running), 1);
    run_arm("arm");

    // cancel in EXPIRED clears done
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk_idle("cancel_expired");

    // both starts together: arm wins; start during COUNT ignored
    start_arm = 1'b1; start_entry = 1'b1;
    step();
    start_arm = 1'b0; start_entry = 1'b0;
    chk("prio_timer", 32'(timer), 3);
    step(); step();
    start_entry = 1'b1;
    step();
    start_entry = 1'b0;
    chk("restart_ignored_timer", 32'(timer), 3);
    chk("restart_ignored_running", 32'(running), 1);
    step();
    chk("restart_ignored_dec", 32'(timer), 2);
    chk("restart_ignored_tick", 32'(sec_tick), 1);

    // cancel during COUNT with timer=2
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk_idle("cancel_count");
    for (int c = 0; c < 6; c++) begin
      step();
      chk("cancel_count_no_exp", 32'(expired), 0);
    end
    chk_idle("cancel_count_settled");

    // cancel with start_arm in IDLE stays IDLE
    cancel = 1'b1; start_arm = 1'b1;
    step();
    cancel = 1'b0; start_arm = 1'b0;
    chk_idle("cancel_vs_start");

    // hold mid-second for 5 cycles
    start_entry = 1'b1;
    step();
    start_entry = 1'b0;
    chk("entry_load_timer", 32'(timer), 2);
    step(); step();
    hold = 1'b1;
    for (int c = 3; c <= 7; c++) begin
      step();
      chk("hold_timer", 32'(timer), 2);
      chk("hold_tick", 32'(sec_tick), 0);
      chk("hold_running", 32'(running), 1);
    end
    hold = 1'b0;
    for (int c = 8; c <= 13; c++) begin
      step();
      chk("hold_resume_timer", 32'(timer), 32'((c < 9) ? 2 : (c < 13) ? 1 : 0));
      chk("hold_resume_tick", 32'(sec_tick), 32'(c == 9 || c == 13));
      chk("hold_resume_expired", 32'(expired), 32'(c == 13));
    end
    chk("hold_done", 32'(done), 1);

    // re-arm from EXPIRED; hold has no effect here
    hold = 1'b1;
    step();
    hold = 1'b0;
    chk("expired_state_done", 32'(done), 1);
    chk("expired_state_pulse", 32'(expired), 0);
    start_entry = 1'b1;
    step();
    start_entry = 1'b0;
    chk("rearm_timer", 32'(timer), 2);
    chk("rearm_done", 32'(done), 0);
    chk("rearm_running", 32'(running), 1);

    // asynchronous reset while timer=1
    for (int c = 0; c < 4; c++) step();
    chk("pre_reset_timer", 32'(timer), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("post_async_no_exp", 32'(expired), 0);
      chk("post_async_running", 32'(running), 0);
    end

    // first start after reset counts normally
    start_arm = 1'b1;
    step();
    start_arm = 1'b0;
    chk("post_async_load", 32'(timer), 3);
    run_arm("post_async_arm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arm_countdown_ctrl.md
# arm_countdown_ctrl

Countdown sequencer for the alarm's arming and entry delays. It counts a configurable number of seconds down from a loaded value, drives the two-digit `timer` value shown on the left seven-segment pair, and signals the system FSM when the delay has run out. It replaces free-running timer logic in the top level. It runs from the single 50 MHz board clock.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: clock cycles per second tick. Legal range is 2 and up.
- `ARM_S`, default 30: seconds loaded by `start_arm`. Legal range is 1..99.
- `ENTRY_S`, default 15: seconds loaded by `start_entry`. Legal range is 1..99.

Ports:
- `clk` in, 1 bit: system clock, rising edge.
- `rst_n` in, 1 bit: reset, asynchronous and active-low.
- `start_arm` in, 1 bit: single-cycle request to load `ARM_S` and count down.
- `start_entry` in, 1 bit: single-cycle request to load `ENTRY_S` and count down.
- `cancel` in, 1 bit: level; abort or clear and return to idle.
- `hold` in, 1 bit: level; freeze the countdown while high.
- `timer` out, 7 bits: remaining seconds, 0..99, unsigned.
- `running` out, 1 bit: high while in COUNT.
- `expired` out, 1 bit: single-cycle pulse when the count reaches 0.
- `done` out, 1 bit: high in EXPIRED until cleared.
- `sec_tick` out, 1 bit: single-cycle pulse on every decrement, for display flashing.

## Operation
States:
- IDLE: `timer` = 0; `running`, `done` and `expired` are 0.
- COUNT: `running` = 1. A prescaler counts 0..CLK_HZ-1. When it wraps, `timer` decrements by 1 and `sec_tick` pulses.
- EXPIRED: `timer` = 0, `done` = 1, `running` = 0.

Transitions:
- IDLE to COUNT on `start_arm` or `start_entry`. The matching parameter is loaded into `timer` and the prescaler is cleared.
- If `start_arm` and `start_entry` are high in the same cycle, `start_arm` wins.
- COUNT to EXPIRED when a tick occurs with `timer` = 1. In that cycle `timer` becomes 0, `expired` = 1 and `sec_tick` = 1.
- COUNT to IDLE on `cancel`.
- EXPIRED to IDLE on `cancel`.
- EXPIRED to COUNT on a start request (re-arm), loaded as from IDLE.

Boundary rules:
- `cancel` has priority over every other input, in every state. If `cancel` and a start are high in the same cycle, the next state is IDLE.
- A start request in COUNT is ignored. There is no restart while running.
- `hold` high in COUNT freezes both the prescaler and `timer`. Counting resumes from the frozen prescaler value when `hold` drops. `hold` has no effect in IDLE or EXPIRED.
- `hold` does not block `cancel`.
- `timer` never underflows: decrement happens only when `timer` ≥ 1.
- Widths:
  - prescaler is $clog2(CLK_HZ) bits, compared against CLK_HZ-1;
  - `timer` is 7 bits, and load values are truncated to 7 bits.

Reset:
- `rst_n` low forces IDLE immediately, without waiting for a clock edge.
- All outputs go to 0 and the prescaler goes to 0.
- Reset release takes effect on the first rising edge with `rst_n` high.
- Reset in the middle of a count discards the count. No `expired` pulse is produced.

## Timing
- All outputs are registered.
- Start request sampled at edge N:
  - from edge N, `running` = 1 and `timer` = load value;
  - the first decrement occurs at edge N+CLK_HZ.
- With no hold, `expired` is asserted at edge N + load×CLK_HZ and lasts exactly one cycle.
- `done` rises in the same cycle as `expired`.
- Each cycle that `hold` is high during COUNT extends the remaining time by one cycle.
- `cancel` sampled at edge M: IDLE outputs from edge M.
- `sec_tick` and `expired` are never asserted for more than one consecutive cycle.

## Test plan
Benches use `CLK_HZ` = 4, `ARM_S` = 3 and `ENTRY_S` = 2.
- **Basic arm count.** Reset, then `start_arm` for one cycle → `timer` = 3 from the next edge, then 2, 1, 0 at 4-cycle intervals. `expired` is a one-cycle pulse in the cycle `timer` reaches 0. `done` stays high and `running` falls.
- **Start priority and restart rule.** `start_arm` and `start_entry` together → `timer` = 3. A second `start_entry` during COUNT → ignored, count unchanged.
- **Hold.** `start_entry`, then `hold` high for 5 cycles mid-second → `timer` frozen for 5 cycles. `expired` arrives at 8 + 5 = 13 cycles after start.
- **Cancel priority.** `cancel` with `start_arm` in IDLE → stays IDLE. `cancel` during COUNT with `timer` = 2 → `timer` = 0, `running` = 0, no `expired`. `cancel` in EXPIRED → `done` clears.
- **Re-arm from EXPIRED.** `start_entry` while in EXPIRED → `timer` = 2, `done` = 0, `running` = 1.
- **Asynchronous reset.** Drop `rst_n` between clock edges while `timer` = 1 → all outputs 0 without waiting for an edge. No `expired` pulse after release. The first start after release counts normally.
